// File: rtl/gcd_operand_entry.sv
// Keypad front end for the GCD datapath: turns decimal key strokes into two
// binary operands and a start strobe held for START_LEN cycles per launch.
module gcd_operand_entry #(
  parameter int         WIDTH      = 5,
  parameter int         MAX_DIGITS = 2,
  parameter int         ACC_W      = 7,
  parameter int         START_LEN  = 1,
  parameter logic [3:0] KEY_ENTER  = 4'hA,
  parameter logic [3:0] KEY_CLEAR  = 4'hB
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [WIDTH-1:0] number1,
  output logic [WIDTH-1:0] number2,
  output logic             S,
  output logic             entry_sel,
  output logic             err
);

  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
  localparam int CNT_W  = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [ACC_W-1:0] OP_MAX = ACC_W'((1 << WIDTH) - 1);

  typedef enum logic [1:0] {
    ST_ENT_A = 2'd0,
    ST_ENT_B = 2'd1,
    ST_START = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   num1_q, num1_d;
  logic [WIDTH-1:0]   num2_q, num2_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic entering_s, is_digit_s, is_enter_s, is_clear_s;
  logic digit_ok_s, enter_bad_s, accept_s, start_done_s;

  assign entering_s   = (state_q != ST_START);
  assign is_digit_s   = key_valid && (key_code <= 4'd9) && entering_s;
  assign is_enter_s   = key_valid && (key_code == KEY_ENTER) && entering_s;
  assign is_clear_s   = key_valid && (key_code == KEY_CLEAR) && entering_s;
  assign digit_ok_s   = is_digit_s && (dcnt_q < DCNT_W'(MAX_DIGITS));
  assign enter_bad_s  = (dcnt_q == {DCNT_W{1'b0}}) || (acc_q == {ACC_W{1'b0}}) ||
                        (acc_q > OP_MAX);
  assign accept_s     = is_enter_s && !enter_bad_s;
  assign start_done_s = (state_q == ST_START) && (cnt_q == CNT_W'(START_LEN - 1));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_ENT_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ENT_A: begin
        if (accept_s) begin
          state_d = ST_ENT_B;
        end else begin
          state_d = ST_ENT_A;
        end
      end
      ST_ENT_B: begin
        if (is_clear_s) begin
          state_d = ST_ENT_A;
        end else if (accept_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_ENT_B;
        end
      end
      ST_START: begin
        if (start_done_s) begin
          state_d = ST_ENT_A;
        end else begin
          state_d = ST_START;
        end
      end
      default: state_d = ST_ENT_A;
    endcase
  end

  always_comb begin
    S         = (state_q == ST_START);
    entry_sel = (state_q == ST_ENT_B);
    number1   = num1_q;
    number2   = num2_q;
    err       = err_q;
  end

  // Operand datapath; keys are already masked off while the launch is running.
  always_comb begin
    acc_d  = acc_q;
    dcnt_d = dcnt_q;
    opa_d  = opa_q;
    num1_d = num1_q;
    num2_d = num2_q;
    err_d  = err_q;
    if ((state_q == ST_START) && !start_done_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
    if (is_clear_s) begin
      acc_d  = {ACC_W{1'b0}};
      dcnt_d = {DCNT_W{1'b0}};
      opa_d  = {WIDTH{1'b0}};
      err_d  = 1'b0;
    end else if (is_enter_s) begin
      acc_d  = {ACC_W{1'b0}};
      dcnt_d = {DCNT_W{1'b0}};
      if (enter_bad_s) begin
        err_d = 1'b1;
      end else if (state_q == ST_ENT_A) begin
        opa_d = acc_q[WIDTH-1:0];
        err_d = 1'b0;
      end else begin
        num1_d = opa_q;
        num2_d = acc_q[WIDTH-1:0];
        err_d  = 1'b0;
      end
    end else if (digit_ok_s) begin
      acc_d  = (acc_q * ACC_W'(10)) + ACC_W'(key_code);
      dcnt_d = dcnt_q + DCNT_W'(1);
      err_d  = 1'b0;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      acc_q  <= {ACC_W{1'b0}};
      dcnt_q <= {DCNT_W{1'b0}};
      opa_q  <= {WIDTH{1'b0}};
      num1_q <= {WIDTH{1'b0}};
      num2_q <= {WIDTH{1'b0}};
      err_q  <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      acc_q  <= acc_d;
      dcnt_q <= dcnt_d;
      opa_q  <= opa_d;
      num1_q <= num1_d;
      num2_q <= num2_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gcd_operand_entry.sv
// Bench for gcd_operand_entry: two instances (START_LEN 1 and 3) share one key
// stream and are compared every cycle against an integer model of the keypad rules.
module tb_gcd_operand_entry;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [4:0] n1_0, n2_0, n1_1, n2_1;
  logic       s0, s1, es0, es1, e0, e1;

  int checks = 0;
  int failures = 0;

  // Model state: phase 0 = entering A, 1 = entering B, 2 = launch running
  int m_ph[2], m_val[2], m_cnt[2], m_left[2], m_opa[2], m_n1[2], m_n2[2], m_err[2];
  int m_len[2];

  always #5 CLK = ~CLK;

  gcd_operand_entry #(.START_LEN(1)) dut0 (
    .CLK(CLK), .Reset(Reset), .key_valid(key_valid), .key_code(key_code),
    .number1(n1_0), .number2(n2_0), .S(s0), .entry_sel(es0), .err(e0)
  );

  gcd_operand_entry #(.START_LEN(3)) dut1 (
    .CLK(CLK), .Reset(Reset), .key_valid(key_valid), .key_code(key_code),
    .number1(n1_1), .number2(n2_1), .S(s1), .entry_sel(es1), .err(e1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit rst, input bit v, input int code);
    if (rst) begin
      m_ph[k] = 0; m_val[k] = 0; m_cnt[k] = 0; m_left[k] = 0;
      m_opa[k] = 0; m_n1[k] = 0; m_n2[k] = 0; m_err[k] = 0;
    end else if (m_ph[k] == 2) begin
      m_left[k]--;
      if (m_left[k] == 0) m_ph[k] = 0;
    end else if (v) begin
      if (code <= 9) begin
        if (m_cnt[k] < 2) begin
          m_val[k] = m_val[k] * 10 + code;
          m_cnt[k]++;
          m_err[k] = 0;
        end
      end else if (code == 10) begin
        if (m_cnt[k] == 0 || m_val[k] == 0 || m_val[k] > 31) begin
          m_err[k] = 1;
        end else begin
          m_err[k] = 0;
          if (m_ph[k] == 0) begin
            m_opa[k] = m_val[k];
            m_ph[k] = 1;
          end else begin
            m_n1[k] = m_opa[k];
            m_n2[k] = m_val[k];
            m_ph[k] = 2;
            m_left[k] = m_len[k];
          end
        end
        m_val[k] = 0;
        m_cnt[k] = 0;
      end else if (code == 11) begin
        m_val[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_ph[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("d0_number1", int'(n1_0), m_n1[0]);
    chk("d0_number2", int'(n2_0), m_n2[0]);
    chk("d0_S", int'(s0), (m_ph[0] == 2) ? 1 : 0);
    chk("d0_entry_sel", int'(es0), (m_ph[0] == 1) ? 1 : 0);
    chk("d0_err", int'(e0), m_err[0]);
    chk("d1_number1", int'(n1_1), m_n1[1]);
    chk("d1_number2", int'(n2_1), m_n2[1]);
    chk("d1_S", int'(s1), (m_ph[1] == 2) ? 1 : 0);
    chk("d1_entry_sel", int'(es1), (m_ph[1] == 1) ? 1 : 0);
    chk("d1_err", int'(e1), m_err[1]);
  endtask

  task automatic tick(input bit rst, input bit v, input int code);
    Reset = rst;
    key_valid = v;
    key_code = code[3:0];
    @(posedge CLK);
    model_step(0, rst, v, code);
    model_step(1, rst, v, code);
    #1;
    compare_all();
  endtask

  task automatic key(input int c);
    tick(1'b0, 1'b1, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0);
  endtask

  initial begin
    m_len[0] = 1;
    m_len[1] = 3;
    Reset = 1'b1;
    key_valid = 1'b0;
    key_code = 4'd0;
    tick(1'b1, 1'b0, 0);
    chk("reset_number1", int'(n1_0), 0);
    chk("reset_S", int'(s0), 0);
    chk("reset_err", int'(e0), 0);

    // 10 and 5 launched
    key(1); key(0); key(10);
    chk("t1_sel_b", int'(es0), 1);
    key(5); key(10);
    chk("t1_number1", int'(n1_0), 10);
    chk("t1_number2", int'(n2_0), 5);
    chk("t1_S_high", int'(s0), 1);
    chk("t1_sel_back", int'(es0), 0);
    chk("t1_model_n1", m_n1[0], 10);
    idle(1);
    chk("t1_S_low", int'(s0), 0);
    idle(3);

    // out-of-range operand rejected
    key(3); key(2); key(10);
    chk("t2_err", int'(e0), 1);
    chk("t2_sel", int'(es0), 0);
    key(7);
    chk("t2_err_clr", int'(e0), 0);

    // third digit dropped
    key(11);
    key(1); key(2); key(3); key(10); key(9); key(10);
    chk("t3_number1", int'(n1_0), 12);
    chk("t3_number2", int'(n2_0), 9);
    chk("t3_model_n2", m_n2[0], 9);
    idle(4);

    // abort keeps last launched operands
    key(1); key(0); key(10); key(5); key(10);
    idle(4);
    key(4); key(10);
    chk("t4_sel_b", int'(es0), 1);
    key(11);
    chk("t4_sel_a", int'(es0), 0);
    chk("t4_number1", int'(n1_0), 10);
    chk("t4_number2", int'(n2_0), 5);
    chk("t4_no_S", int'(s0), 0);
    key(10);
    chk("t4_empty_err", int'(e0), 1);

    // three-cycle launch on the second instance ignores keys
    key(11);
    key(3); key(1); key(10); key(1); key(10);
    chk("t5_number1", int'(n1_1), 31);
    chk("t5_number2", int'(n2_1), 1);
    chk("t5_S_c1", int'(s1), 1);
    key(5);
    chk("t5_S_c2", int'(s1), 1);
    key(11);
    chk("t5_S_c3", int'(s1), 1);
    idle(1);
    chk("t5_S_done", int'(s1), 0);
    chk("t5_sel", int'(es1), 0);
    key(2); key(10);
    chk("t5_clean_sel", int'(es1), 1);
    chk("t5_clean_err", int'(e1), 0);
    idle(4);

    // reset in the S-high cycle
    key(11);
    key(1); key(10); key(2); key(10);
    chk("t6_S_high", int'(s0), 1);
    tick(1'b1, 1'b0, 0);
    chk("t6_S_drop", int'(s0), 0);
    chk("t6_number1", int'(n1_0), 0);
    chk("t6_number2", int'(n2_0), 0);
    chk("t6_S1_drop", int'(s1), 0);
    key(0); key(10);
    chk("t6_zero_err", int'(e0), 1);
    chk("t6_sel", int'(es0), 0);

    // random key stream
    for (int i = 0; i < 4000; i++) begin
      int r;
      int r2;
      r = $urandom_range(0, 99);
      if (r < 1) begin
        tick(1'b1, 1'b0, 0);
      end else if (r < 35) begin
        tick(1'b0, 1'b0, $urandom_range(0, 15));
      end else begin
        r2 = $urandom_range(0, 19);
        if (r2 < 5) key($urandom_range(0, 3));
        else if (r2 < 11) key($urandom_range(0, 9));
        else if (r2 < 15) key(10);
        else if (r2 < 17) key(11);
        else key($urandom_range(12, 15));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
